// File: rtl/dp_sequencer.sv
// Control unit for the 4-bit accumulator datapath: fetches 8-bit instructions from a
// synchronous ROM, decodes them and drives the datapath control interface.
module dp_sequencer #(
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [ADDR_W-1:0] instr_addr,
  input  logic [7:0]        instr_data,
  output logic [3:0]        mux_in_data,
  output logic [3:0]        alu_in_data,
  output logic              mux_sel_data,
  output logic              load,
  output logic [1:0]        alu_sel_data,
  input  logic              carry_in,
  input  logic [3:0]        reg_in,
  output logic              busy,
  output logic              halted,
  output logic              illegal,
  output logic              carry_flag,
  output logic [CNT_W-1:0]  retired
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALTED
  } state_t;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_LDI  = 4'h1,
    OP_ADD  = 4'h2,
    OP_SUB  = 4'h3,
    OP_AND  = 4'h4,
    OP_OR   = 4'h5,
    OP_JMP  = 4'h6,
    OP_JC   = 4'h7,
    OP_JZ   = 4'h8,
    OP_HALT = 4'hF
  } op_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_next;
  logic [ADDR_W-1:0]  w_jump_target;
  logic [7:0]         r_ir;
  logic               r_carry;
  logic               r_illegal;
  logic [CNT_W-1:0]   r_retired;
  op_t                w_op;
  logic [3:0]         w_imm;
  logic               w_start_ok;
  logic               w_cap_carry;
  logic               w_bad_op;
  logic               w_load;
  logic               w_mux_sel;
  logic [1:0]         w_alu_sel;
  logic [3:0]         w_mux_in;
  logic [3:0]         w_alu_in;

  assign w_op          = op_t'(r_ir[7:4]);
  assign w_imm         = r_ir[3:0];
  assign w_jump_target = ADDR_W'(w_imm);
  assign w_start_ok    = start && ((r_state == S_IDLE) || (r_state == S_HALTED));

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the
    // case statements can leave one unassigned and infer a latch.
    w_next_state = r_state;
    w_pc_next    = r_pc + ADDR_W'(1);
    w_load       = 1'b0;
    w_mux_sel    = 1'b0;
    w_alu_sel    = 2'b00;
    w_mux_in     = 4'h0;
    w_alu_in     = 4'h0;
    w_cap_carry  = 1'b0;
    w_bad_op     = 1'b0;
    case (r_state)
      S_IDLE, S_HALTED: if (start) w_next_state = S_FETCH;
      S_FETCH:          w_next_state = S_DECODE;
      S_DECODE:         w_next_state = S_EXEC;
      S_EXEC: begin
        w_next_state = S_FETCH;
        case (w_op)
          OP_NOP: ;
          OP_LDI: begin
            w_load   = 1'b1;
            w_mux_in = w_imm;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            w_load      = 1'b1;
            w_mux_sel   = 1'b1;
            w_alu_in    = w_imm;
            w_cap_carry = (w_op == OP_ADD) || (w_op == OP_SUB);
            case (w_op)
              OP_SUB:  w_alu_sel = 2'b01;
              OP_AND:  w_alu_sel = 2'b10;
              OP_OR:   w_alu_sel = 2'b11;
              default: w_alu_sel = 2'b00;
            endcase
          end
          OP_JMP: w_pc_next = w_jump_target;
          OP_JC:  if (r_carry) w_pc_next = w_jump_target;
          // reg_in already holds the previous instruction's result at this point
          OP_JZ:  if (reg_in == 4'h0) w_pc_next = w_jump_target;
          OP_HALT: begin
            w_next_state = S_HALTED;
            w_pc_next    = r_pc;
          end
          default: w_bad_op = 1'b1;
        endcase
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_pc      <= '0;
      r_ir      <= 8'h00;
      r_carry   <= 1'b0;
      r_illegal <= 1'b0;
      r_retired <= '0;
    end else begin
      r_state <= w_next_state;
      if (r_state == S_DECODE) r_ir <= instr_data;
      if (w_start_ok) begin
        r_pc      <= '0;
        r_carry   <= 1'b0;
        r_illegal <= 1'b0;
        r_retired <= '0;
      end else if (r_state == S_EXEC) begin
        r_pc <= w_pc_next;
        if (w_cap_carry) r_carry <= carry_in;
        if (w_bad_op) r_illegal <= 1'b1;
        if (r_retired != '1) r_retired <= r_retired + CNT_W'(1);
      end
    end
  end

  assign instr_addr   = r_pc;
  assign load         = w_load;
  assign mux_sel_data = w_mux_sel;
  assign alu_sel_data = w_alu_sel;
  assign mux_in_data  = w_mux_in;
  assign alu_in_data  = w_alu_in;
  assign busy         = (r_state == S_FETCH) || (r_state == S_DECODE) || (r_state == S_EXEC);
  assign halted       = (r_state == S_HALTED);
  assign illegal      = r_illegal;
  assign carry_flag   = r_carry;
  assign retired      = r_retired;

endmodule

// File: tb/tb_dp_sequencer.sv
// Scoreboard bench for dp_sequencer: an instruction-level model predicts each retired
// instruction; a monitor compares the DUT's EXEC controls and post-instruction state.
module tb_dp_sequencer;
  localparam int ADDR_W = 4;
  localparam int CNT_W  = 8;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] instr_addr;
  logic [7:0]        instr_data;
  logic [3:0]        mux_in_data;
  logic [3:0]        alu_in_data;
  logic              mux_sel_data;
  logic              load;
  logic [1:0]        alu_sel_data;
  logic              carry_in;
  logic [3:0]        reg_in;
  logic              busy;
  logic              halted;
  logic              illegal;
  logic              carry_flag;
  logic [CNT_W-1:0]  retired;

  dp_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .instr_addr   (instr_addr),
    .instr_data   (instr_data),
    .mux_in_data  (mux_in_data),
    .alu_in_data  (alu_in_data),
    .mux_sel_data (mux_sel_data),
    .load         (load),
    .alu_sel_data (alu_sel_data),
    .carry_in     (carry_in),
    .reg_in       (reg_in),
    .busy         (busy),
    .halted       (halted),
    .illegal      (illegal),
    .carry_flag   (carry_flag),
    .retired      (retired)
  );

  always #5 clk = ~clk;

  // Environment: synchronous program ROM and the 4-bit accumulator datapath.
  logic [7:0] rom [16];
  logic [7:0] rom_q;
  always @(posedge clk) rom_q <= rom[instr_addr];
  assign instr_data = rom_q;

  logic [3:0] dp_reg;
  logic [4:0] dp_res;
  always_comb begin
    case (alu_sel_data)
      2'b00:   dp_res = {1'b0, dp_reg} + {1'b0, alu_in_data};
      2'b01:   dp_res = {1'b0, dp_reg} - {1'b0, alu_in_data};
      2'b10:   dp_res = {1'b0, dp_reg & alu_in_data};
      default: dp_res = {1'b0, dp_reg | alu_in_data};
    endcase
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) dp_reg <= 4'h0;
    else if (load) dp_reg <= mux_sel_data ? dp_res[3:0] : mux_in_data;
  end
  assign carry_in = dp_res[4];
  assign reg_in   = dp_reg;

  typedef struct {
    int addr, load, mux_sel, alu_sel, mux_in, alu_in;
    int npc, cf, ret, ill, halt;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  int   phase = 0;
  bit   pending = 0;
  int   model_reg = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction-set model: runs the program from address 0 as a fresh start would.
  task automatic run_model(input int max_instr, output bit did_halt);
    int pc, cf, ill, ret, op, imm, sum;
    exp_t e;
    pc = 0; cf = 0; ill = 0; ret = 0; did_halt = 0;
    for (int n = 0; n < max_instr && !did_halt; n++) begin
      op  = int'(rom[pc][7:4]);
      imm = int'(rom[pc][3:0]);
      e = '{default: 0};
      e.addr = pc;
      e.npc  = (pc + 1) % 16;
      case (op)
        0: ;
        1: begin e.load = 1; e.mux_in = imm; model_reg = imm; end
        2, 3, 4, 5: begin
          e.load = 1; e.mux_sel = 1; e.alu_sel = op - 2; e.alu_in = imm;
          if (op == 2) begin
            sum = model_reg + imm; cf = (sum > 15) ? 1 : 0; model_reg = sum % 16;
          end else if (op == 3) begin
            cf = (model_reg < imm) ? 1 : 0; model_reg = (model_reg - imm + 16) % 16;
          end else if (op == 4) begin
            model_reg = model_reg & imm;
          end else begin
            model_reg = model_reg | imm;
          end
        end
        6: e.npc = imm;
        7: if (cf == 1) e.npc = imm;
        8: if (model_reg == 0) e.npc = imm;
        15: begin did_halt = 1; e.npc = pc; end
        default: ill = 1;
      endcase
      ret = (ret < 255) ? ret + 1 : 255;
      pc = e.npc;
      e.cf = cf; e.ret = ret; e.ill = ill; e.halt = did_halt ? 1 : 0;
      sb.push_back(e);
    end
  endtask

  // Monitor: tracks the three-cycle instruction rhythm from busy and checks the third.
  always @(negedge clk) begin
    if (!rst_n) begin
      pending = 0;
      phase   = 0;
    end else begin
      if (pending) begin
        check("post_pc",      32'(instr_addr), cur.npc);
        check("post_carry",   32'(carry_flag), cur.cf);
        check("post_retired", 32'(retired),    cur.ret);
        check("post_illegal", 32'(illegal),    cur.ill);
        check("post_halted",  32'(halted),     cur.halt);
        pending = 0;
      end
      if (busy && phase == 2) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_exec: got instruction at pc %0d expected none", instr_addr);
        end else begin
          cur = sb.pop_front();
          check("exec_addr",    32'(instr_addr),   cur.addr);
          check("exec_load",    32'(load),         cur.load);
          check("exec_mux_sel", 32'(mux_sel_data), cur.mux_sel);
          check("exec_alu_sel", 32'(alu_sel_data), cur.alu_sel);
          check("exec_mux_in",  32'(mux_in_data),  cur.mux_in);
          check("exec_alu_in",  32'(alu_in_data),  cur.alu_in);
          pending = 1;
        end
      end else begin
        check("ctrl_outside_exec",
              32'({load, mux_sel_data, alu_sel_data, mux_in_data, alu_in_data}), 0);
      end
      phase = busy ? ((phase == 2) ? 0 : phase + 1) : 0;
    end
  end

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 16; i++) rom[i] = v;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    bit timed_out;
    timed_out = 1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      #1;
      if (sb.size() == 0 && !pending) begin
        timed_out = 0;
        break;
      end
    end
    check("drain_timeout", 32'(timed_out), 0);
    sb.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    model_reg = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_program(input int max_instr);
    bit h;
    run_model(max_instr, h);
    pulse_start();
    wait_drain(max_instr * 3 + 20);
    if (!h) do_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  initial begin
    bit h;
    bit seen;
    rst_n = 1'b0;
    start = 1'b0;
    fill_rom(8'hF0);
    #1;
    check("reset_addr",    32'(instr_addr), 0);
    check("reset_flags",   32'({busy, halted, illegal, carry_flag, load}), 0);
    check("reset_retired", 32'(retired), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("idle_no_busy", 32'(busy), 0);

    // LDI 5, ADD 3, HALT
    fill_rom(8'hF0);
    rom[0] = 8'h15; rom[1] = 8'h23;
    run_program(10);
    check("add_result_reg", 32'(reg_in), 8);

    // LDI 15, ADD 2 (carry), JC 3 taken, HALT at 3
    fill_rom(8'hF0);
    rom[0] = 8'h1F; rom[1] = 8'h22; rom[2] = 8'h73; rom[3] = 8'hF0;
    run_program(10);

    // JZ taken, then not taken
    fill_rom(8'hF0);
    rom[0] = 8'h11; rom[1] = 8'h31; rom[2] = 8'h84;
    run_program(10);
    rom[0] = 8'h12;
    run_program(10);

    // Undefined opcode, then a fresh start clears illegal and retired
    fill_rom(8'hF0);
    rom[0] = 8'h90;
    run_program(10);
    check("illegal_sticky", 32'(illegal), 1);
    rom[0] = 8'h00;
    run_program(10);

    // NOP loop: wrap via JMP 0, retired saturation, start ignored while busy
    fill_rom(8'h00);
    rom[15] = 8'h60;
    run_model(260, h);
    pulse_start();
    for (int k = 0; k < 15; k++) begin
      repeat ($urandom_range(5, 30)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_drain(260 * 3 + 20);
    check("retired_saturated", 32'(retired), 255);
    do_reset();

    // Reset asserted during EXEC of an ADD
    fill_rom(8'hF0);
    rom[0] = 8'h13; rom[1] = 8'h24;
    run_model(10, h);
    pulse_start();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (load && mux_sel_data) seen = 1;
    end
    check("saw_add_exec", 32'(seen), 1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_load_drop", 32'(load), 0);
    check("async_flags",     32'({busy, halted, illegal, carry_flag}), 0);
    check("async_outputs",   32'({instr_addr, retired, mux_in_data, alu_in_data}), 0);
    sb.delete();
    model_reg = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("needs_start", 32'(busy), 0);
    run_program(10);

    // Random programs against the instruction-set model
    for (int t = 0; t < 12; t++) begin
      for (int i = 0; i < 16; i++) rom[i] = 8'($urandom_range(0, 255));
      run_program(40);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
